// File: rtl/prog_uart_router.sv
// Programming-UART fan-out: decodes a 0xA5 + target-mask header from the host
// stream, then forwards the raw serial line only to the selected targets.
module prog_uart_router #(
  parameter int CLK_HZ      = 100000000,
  parameter int BAUD        = 115200,
  parameter int N_TX        = 8,
  parameter int TIMEOUT_CYC = 10000000,
  parameter int LED_HOLD    = 5000000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            uart_rx_i,
  output logic [N_TX-1:0] program_tx_o,
  output logic            led_tx_o,
  output logic            busy_o,
  output logic [7:0]      mask_o
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int BIT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int IDLE_W       = $clog2(TIMEOUT_CYC + 1);
  localparam int LED_W        = $clog2(LED_HOLD + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {S_IDLE, S_MASK, S_FWD} state_t;

  logic rx_meta, rx_s, rx_prev, rx_fall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign rx_fall = rx_prev & ~rx_s;

  // byte_vld / frm_err are single-cycle strobes with no backpressure: the main
  // FSM must consume them in the cycle they are high.
  rx_state_t        rx_state, rx_state_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       rx_byte, rx_byte_nxt;
  logic             byte_vld, frm_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state <= RX_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      rx_byte  <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      rx_byte  <= rx_byte_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    bit_cnt_nxt  = bit_cnt;
    bit_idx_nxt  = bit_idx;
    rx_byte_nxt  = rx_byte;
    byte_vld     = 1'b0;
    frm_err      = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        bit_cnt_nxt = '0;
        bit_idx_nxt = '0;
        if (rx_fall) rx_state_nxt = RX_START;
      end
      RX_START: begin
        if (bit_cnt == BIT_W'(HALF_BIT - 1)) begin
          bit_cnt_nxt  = '0;
          rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
        end
      end
      RX_DATA: begin
        if (bit_cnt == BIT_W'(CLKS_PER_BIT - 1)) begin
          bit_cnt_nxt = '0;
          rx_byte_nxt = {rx_s, rx_byte[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_state_nxt = RX_STOP;
        end else begin
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
        end
      end
      RX_STOP: begin
        if (bit_cnt == BIT_W'(CLKS_PER_BIT - 1)) begin
          byte_vld     = rx_s;
          frm_err      = ~rx_s;
          rx_state_nxt = RX_IDLE;
        end else begin
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  state_t            state, state_nxt;
  logic [IDLE_W-1:0] idle_cnt, idle_cnt_nxt;
  logic [7:0]        mask_q, mask_nxt;
  logic [LED_W-1:0]  led_cnt;
  logic              idle_expire;

  // Expiry fires on the idle cycle that completes the count; a low line in the
  // same cycle clears the counter instead, so activity always wins.
  assign idle_expire = rx_s && (idle_cnt >= IDLE_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      idle_cnt <= '0;
      mask_q   <= '0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_cnt_nxt;
      mask_q   <= mask_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    mask_nxt     = mask_q;
    if (!rx_s) idle_cnt_nxt = '0;
    else if (idle_cnt != IDLE_W'(TIMEOUT_CYC)) idle_cnt_nxt = idle_cnt + IDLE_W'(1);
    case (state)
      S_IDLE: begin
        idle_cnt_nxt = '0;
        if (byte_vld && rx_byte == 8'hA5) state_nxt = S_MASK;
      end
      S_MASK: begin
        if (frm_err) begin
          state_nxt = S_IDLE;
        end else if (byte_vld) begin
          if (rx_byte != 8'h00) begin
            mask_nxt  = rx_byte;
            state_nxt = S_FWD;
          end else begin
            state_nxt = S_IDLE;
          end
        end else if (idle_expire) begin
          state_nxt = S_IDLE;
        end
      end
      S_FWD: begin
        if (idle_expire) begin
          state_nxt    = S_IDLE;
          mask_nxt     = 8'h00;
          idle_cnt_nxt = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      program_tx_o <= '1;
      led_cnt      <= '0;
    end else begin
      if (state == S_FWD) program_tx_o <= ~(mask_q[N_TX-1:0] & {N_TX{~rx_s}});
      else program_tx_o <= '1;
      if (state == S_FWD && !rx_s) led_cnt <= LED_W'(LED_HOLD);
      else if (led_cnt != '0) led_cnt <= led_cnt - LED_W'(1);
    end
  end

  assign led_tx_o = (led_cnt != '0);
  assign busy_o   = (state == S_FWD);
  assign mask_o   = mask_q;

endmodule

// File: tb/tb_prog_uart_router.sv
// Bench for prog_uart_router: serial frames are driven bit by bit, every cycle
// is logged, and each scenario compares the log with a frame-level model.
`timescale 1ns/1ps
module tb_prog_uart_router;
  localparam int CPB  = 10;
  localparam int TO   = 200;
  localparam int LH   = 50;
  localparam int MAXC = 12000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] program_tx, mask;
  logic       led, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic       in_log   [MAXC];
  logic [7:0] tx_log   [MAXC];
  logic [7:0] mask_log [MAXC];
  logic       busy_log [MAXC];
  logic       led_log  [MAXC];

  prog_uart_router #(
    .CLK_HZ(1000000), .BAUD(100000), .N_TX(8), .TIMEOUT_CYC(TO), .LED_HOLD(LH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .uart_rx_i(uart_rx),
    .program_tx_o(program_tx), .led_tx_o(led), .busy_o(busy), .mask_o(mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      in_log[cyc]   = uart_rx;
      tx_log[cyc]   = program_tx;
      mask_log[cyc] = mask;
      busy_log[cyc] = busy;
      led_log[cyc]  = led;
    end
  end

  initial begin
    #(MAXC * 10);
    failures++;
    $display("FAIL watchdog cyc=%0d limit=%0d", cyc, MAXC);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // Reference: a target line is low only when the routed mask selects it and
  // the host line was low three cycles earlier.
  function automatic logic [7:0] model_tx(int n, logic [7:0] m);
    return in_log[n-3] ? 8'hFF : ~m;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      uart_rx = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int start);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < CPB; j++) begin
        @(posedge clk); #1;
        uart_rx = fr[k];
        if (k == 0 && j == 0) start = cyc;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      uart_rx = 1'($urandom_range(0, 1));
      #2;
      checks++;
      if (program_tx !== 8'hFF || led !== 1'b0 || busy !== 1'b0 || mask !== 8'h00) begin
        failures++;
        $display("FAIL reset_hold k=%0d tx=%h led=%b busy=%b mask=%h exp tx=ff led=0 busy=0 mask=00",
                 k, program_tx, led, busy, mask);
      end
    end
    @(posedge clk); #1;
    uart_rx = 1'b1;
    rst_n = 1'b1;
    idle(20);
    checks++;
    if (program_tx !== 8'hFF || busy !== 1'b0 || mask !== 8'h00) begin
      failures++;
      $display("FAIL reset_release tx=%h busy=%b mask=%h exp ff/0/00", program_tx, busy, mask);
    end
  endtask

  task automatic test_routing(output int sp);
    int sa, sm;
    send_byte(8'hA5, 1'b1, sa);
    send_byte(8'h05, 1'b1, sm);
    send_byte(8'h3C, 1'b1, sp);
    idle(10);
    checks++;
    if (busy_log[sm+97] !== 1'b0 || busy_log[sm+98] !== 1'b1) begin
      failures++;
      $display("FAIL routing_busy_edge got=%b%b exp=01", busy_log[sm+97], busy_log[sm+98]);
    end
    checks++;
    if (mask_log[sm+98] !== 8'h05) begin
      failures++;
      $display("FAIL routing_mask got=%h exp=05", mask_log[sm+98]);
    end
    checks++;
    if (led_log[sp+2] !== 1'b0 || led_log[sp+3] !== 1'b1) begin
      failures++;
      $display("FAIL routing_led_rise got=%b%b exp=01", led_log[sp+2], led_log[sp+3]);
    end
    for (int n = sa; n < sm + 100; n++) begin
      checks++;
      if (tx_log[n] !== model_tx(n, 8'h00)) begin
        failures++;
        $display("FAIL routing_header_tx cyc=%0d got=%h exp=%h", n, tx_log[n], model_tx(n, 8'h00));
      end
    end
    for (int n = sp; n <= sp + 105; n++) begin
      checks++;
      if (tx_log[n] !== model_tx(n, 8'h05)) begin
        failures++;
        $display("FAIL routing_payload_tx cyc=%0d got=%h exp=%h", n, tx_log[n], model_tx(n, 8'h05));
      end
    end
  endtask

  task automatic test_timeout();
    int lin, s;
    idle(TO + 20);
    lin = -1;
    for (int n = 0; n < cyc; n++) if (in_log[n] === 1'b0) lin = n;
    checks++;
    if (busy_log[lin+202] !== 1'b1 || busy_log[lin+203] !== 1'b0) begin
      failures++;
      $display("FAIL timeout_busy_fall got=%b%b exp=10", busy_log[lin+202], busy_log[lin+203]);
    end
    checks++;
    if (mask_log[lin+202] !== 8'h05 || mask_log[lin+203] !== 8'h00) begin
      failures++;
      $display("FAIL timeout_mask got=%h,%h exp=05,00", mask_log[lin+202], mask_log[lin+203]);
    end
    checks++;
    if (led_log[lin+52] !== 1'b1 || led_log[lin+53] !== 1'b0) begin
      failures++;
      $display("FAIL led_hold_end got=%b%b exp=10", led_log[lin+52], led_log[lin+53]);
    end
    send_byte(8'h3C, 1'b1, s);
    idle(10);
    for (int n = s; n < cyc; n++) begin
      checks++;
      if (tx_log[n] !== 8'hFF || busy_log[n] !== 1'b0) begin
        failures++;
        $display("FAIL timeout_no_fwd cyc=%0d tx=%h busy=%b exp ff/0", n, tx_log[n], busy_log[n]);
      end
    end
  endtask

  task automatic test_no_session(input logic [7:0] b0, input logic [7:0] b1, input int gap);
    int s0, s1, s2;
    send_byte(b0, 1'b1, s0);
    idle(gap);
    send_byte(b1, 1'b1, s1);
    send_byte(8'h3C, 1'b1, s2);
    idle(10);
    for (int n = s0; n < cyc; n++) begin
      checks++;
      if (tx_log[n] !== 8'hFF || busy_log[n] !== 1'b0 || mask_log[n] !== 8'h00) begin
        failures++;
        $display("FAIL no_session_%h_%h cyc=%0d tx=%h busy=%b mask=%h exp ff/0/00",
                 b0, b1, n, tx_log[n], busy_log[n], mask_log[n]);
      end
    end
  endtask

  task automatic test_framing();
    int sa, sm, s1, s2;
    send_byte(8'hA5, 1'b1, sa);
    send_byte(8'h05, 1'b0, sm);
    idle(20);
    for (int n = sa; n < cyc; n++) begin
      checks++;
      if (busy_log[n] !== 1'b0 || tx_log[n] !== 8'hFF) begin
        failures++;
        $display("FAIL framing_reject cyc=%0d busy=%b tx=%h exp 0/ff", n, busy_log[n], tx_log[n]);
      end
    end
    send_byte(8'hA5, 1'b1, s1);
    send_byte(8'h01, 1'b1, s2);
    idle(5);
    checks++;
    if (busy_log[s2+97] !== 1'b0 || busy_log[s2+98] !== 1'b1 || mask_log[s2+98] !== 8'h01) begin
      failures++;
      $display("FAIL framing_recover busy=%b%b mask=%h exp 01/01",
               busy_log[s2+97], busy_log[s2+98], mask_log[s2+98]);
    end
  endtask

  task automatic test_mid_reset();
    int sp, s3, sa, sm, sp2, rel;
    fork
      send_byte(8'h0F, 1'b1, sp);
      begin
        repeat (56) @(posedge clk);
        #2;
        checks++;
        if (program_tx !== 8'hFE || busy !== 1'b1 || led !== 1'b1 || mask !== 8'h01) begin
          failures++;
          $display("FAIL midreset_before tx=%h busy=%b led=%b mask=%h exp fe/1/1/01",
                   program_tx, busy, led, mask);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (program_tx !== 8'hFF || busy !== 1'b0 || led !== 1'b0 || mask !== 8'h00) begin
          failures++;
          $display("FAIL midreset_async tx=%h busy=%b led=%b mask=%h exp ff/0/0/00",
                   program_tx, busy, led, mask);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rel = cyc;
      end
    join
    idle(150);
    send_byte(8'h3C, 1'b1, s3);
    idle(10);
    for (int n = rel; n < cyc; n++) begin
      checks++;
      if (busy_log[n] !== 1'b0 || tx_log[n] !== 8'hFF) begin
        failures++;
        $display("FAIL midreset_ignore cyc=%0d busy=%b tx=%h exp 0/ff", n, busy_log[n], tx_log[n]);
      end
    end
    send_byte(8'hA5, 1'b1, sa);
    send_byte(8'h02, 1'b1, sm);
    send_byte(8'h3C, 1'b1, sp2);
    idle(10);
    checks++;
    if (busy_log[sm+98] !== 1'b1 || mask_log[sm+98] !== 8'h02) begin
      failures++;
      $display("FAIL midreset_new_header busy=%b mask=%h exp 1/02", busy_log[sm+98], mask_log[sm+98]);
    end
    for (int n = sp2; n <= sp2 + 105; n++) begin
      checks++;
      if (tx_log[n] !== model_tx(n, 8'h02)) begin
        failures++;
        $display("FAIL midreset_fwd_tx cyc=%0d got=%h exp=%h", n, tx_log[n], model_tx(n, 8'h02));
      end
    end
    idle(TO + 20);
  endtask

  task automatic test_back_to_back();
    int sa, sm, s, sp0;
    logic [7:0] m, pl;
    m = 8'($urandom_range(1, 255));
    send_byte(8'hA5, 1'b1, sa);
    send_byte(m, 1'b1, sm);
    sp0 = 0;
    for (int k = 0; k < 5; k++) begin
      pl = (k == 2) ? 8'hA5 : 8'($urandom_range(0, 255));
      send_byte(pl, 1'b1, s);
      if (k == 0) sp0 = s;
      idle($urandom_range(0, 40));
    end
    idle(10);
    for (int n = sm + 98; n < cyc; n++) begin
      checks++;
      if (busy_log[n] !== 1'b1 || mask_log[n] !== m) begin
        failures++;
        $display("FAIL b2b_session cyc=%0d busy=%b mask=%h exp 1/%h", n, busy_log[n], mask_log[n], m);
      end
    end
    for (int n = sp0; n < cyc; n++) begin
      checks++;
      if (tx_log[n] !== model_tx(n, m)) begin
        failures++;
        $display("FAIL b2b_tx cyc=%0d got=%h exp=%h", n, tx_log[n], model_tx(n, m));
      end
    end
    idle(TO + 20);
    checks++;
    if (busy_log[cyc-1] !== 1'b0 || mask_log[cyc-1] !== 8'h00) begin
      failures++;
      $display("FAIL b2b_end busy=%b mask=%h exp 0/00", busy_log[cyc-1], mask_log[cyc-1]);
    end
  endtask

  initial begin
    int sp;
    test_reset();
    test_routing(sp);
    test_timeout();
    test_no_session(8'hA4, 8'h05, 0);
    test_no_session(8'hA5, 8'h00, 0);
    test_no_session(8'hA5, 8'h05, TO + 50);
    test_framing();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
